// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the SRAM.
// slave: arbiter view. master: environment view (masters plus SRAM macro).
interface dmem_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic          mem_cen;
    logic          mem_wen;
    logic          mem_oen;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output mem_cen, mem_wen, mem_oen, mem_a, mem_d,
        input  mem_q
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  mem_cen, mem_wen, mem_oen, mem_a, mem_d,
        output mem_q
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the 128x32 data
// SRAM (active-low CEN/WEN/OEN, macro clocked on inverted clk).
// Every output, including the SRAM controls, comes straight from a flop.
module dmem_arbiter #(
    parameter int AW      = 7,
    parameter int DW      = 32,
    parameter int RD_WAIT = 0
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

    localparam logic [1:0] WAIT_INIT = 2'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);

    state_t        state_q,    state_d;
    logic          rr_last_q,  rr_last_d;
    logic          owner_q,    owner_d;
    logic          we_q,       we_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic [1:0]    cnt_q,      cnt_d;
    logic          m0_ack_q,   m0_ack_d;
    logic          m1_ack_q,   m1_ack_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          mem_cen_q,  mem_cen_d;
    logic          mem_wen_q,  mem_wen_d;
    logic          mem_oen_q,  mem_oen_d;
    logic [AW-1:0] mem_a_q,    mem_a_d;
    logic [DW-1:0] mem_d_q,    mem_d_d;

    logic          grant1;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          enter_done;

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        mem_cen_d  = 1'b1;
        mem_wen_d  = 1'b1;
        mem_oen_d  = 1'b1;
        mem_a_d    = mem_a_q;
        mem_d_d    = mem_d_q;
        enter_done = 1'b0;

        // On a tie the master that did not win last time is granted.
        grant1    = bus.m1_req && (!bus.m0_req || !rr_last_q);
        sel_we    = grant1 ? bus.m1_we    : bus.m0_we;
        sel_addr  = grant1 ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = grant1 ? bus.m1_wdata : bus.m0_wdata;

        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d   = CMD;
                    owner_d   = grant1;
                    rr_last_d = grant1;
                    we_d      = sel_we;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    mem_cen_d = 1'b0;
                    mem_a_d   = sel_addr;
                    if (sel_we) begin
                        mem_wen_d = 1'b0;
                        mem_d_d   = sel_wdata;
                    end else begin
                        mem_oen_d = 1'b0;
                    end
                end
            end
            CMD: begin
                if (!we_q && (RD_WAIT != 0)) begin
                    state_d   = WAIT;
                    cnt_d     = WAIT_INIT;
                    mem_oen_d = 1'b0;
                end else begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d     = cnt_q - 2'd1;
                    mem_oen_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ack the owner and, for reads, capture SRAM data on the edge entering DONE.
        if (enter_done) begin
            if (owner_q) begin
                m1_ack_d = 1'b1;
                if (!we_q) m1_rdata_d = bus.mem_q;
            end else begin
                m0_ack_d = 1'b1;
                if (!we_q) m0_rdata_d = bus.mem_q;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            mem_cen_q  <= 1'b1;
            mem_wen_q  <= 1'b1;
            mem_oen_q  <= 1'b1;
            mem_a_q    <= '0;
            mem_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            mem_cen_q  <= mem_cen_d;
            mem_wen_q  <= mem_wen_d;
            mem_oen_q  <= mem_oen_d;
            mem_a_q    <= mem_a_d;
            mem_d_q    <= mem_d_d;
        end
    end

    assign bus.m0_ack   = m0_ack_q;
    assign bus.m1_ack   = m1_ack_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.mem_cen  = mem_cen_q;
    assign bus.mem_wen  = mem_wen_q;
    assign bus.mem_oen  = mem_oen_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_d    = mem_d_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_WAIT 0, 2, 3), each with its
// own behavioural SRAM clocked on the falling edge.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    logic [31:0] ref_mem [128];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(7), .DW(32)) bus0 ();
    dmem_arbiter_if #(.AW(7), .DW(32)) bus2 ();
    dmem_arbiter_if #(.AW(7), .DW(32)) bus3 ();

    dmem_arbiter #(.AW(7), .DW(32), .RD_WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_arbiter #(.AW(7), .DW(32), .RD_WAIT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    dmem_arbiter #(.AW(7), .DW(32), .RD_WAIT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    logic [31:0] sram0 [128];
    logic [31:0] sram2 [128];
    logic [31:0] sram3 [128];
    logic [31:0] q0, q2, q3;

    // Behavioural SRAM macros, clocked on the inverted clock.
    always @(negedge clk) begin
        if (!bus0.mem_cen) begin
            if (!bus0.mem_wen) sram0[bus0.mem_a] <= bus0.mem_d;
            else               q0 <= sram0[bus0.mem_a];
        end
        if (!bus2.mem_cen) begin
            if (!bus2.mem_wen) sram2[bus2.mem_a] <= bus2.mem_d;
            else               q2 <= sram2[bus2.mem_a];
        end
        if (!bus3.mem_cen) begin
            if (!bus3.mem_wen) sram3[bus3.mem_a] <= bus3.mem_d;
            else               q3 <= sram3[bus3.mem_a];
        end
    end

    assign bus0.mem_q = q0;
    assign bus2.mem_q = q2;
    assign bus3.mem_q = q3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_env();
        for (int i = 0; i < 128; i++) begin
            sram0[i] = '0; sram2[i] = '0; sram3[i] = '0; ref_mem[i] = '0;
        end
        sram0[0] = 32'd15; sram0[1] = 32'd20;
        sram2[0] = 32'd15; sram2[1] = 32'd20;
        sram3[0] = 32'd15; sram3[1] = 32'd20;
        ref_mem[0] = 32'd15; ref_mem[1] = 32'd20;
        bus0.m0_req = 0; bus0.m0_we = 0; bus0.m0_addr = '0; bus0.m0_wdata = '0;
        bus0.m1_req = 0; bus0.m1_we = 0; bus0.m1_addr = '0; bus0.m1_wdata = '0;
        bus2.m0_req = 0; bus2.m0_we = 0; bus2.m0_addr = '0; bus2.m0_wdata = '0;
        bus2.m1_req = 0; bus2.m1_we = 0; bus2.m1_addr = '0; bus2.m1_wdata = '0;
        bus3.m0_req = 0; bus3.m0_we = 0; bus3.m0_addr = '0; bus3.m0_wdata = '0;
        bus3.m1_req = 0; bus3.m1_we = 0; bus3.m1_addr = '0; bus3.m1_wdata = '0;
    endtask

    task automatic test_reset();
        int cen_low;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        // Start a write, then abort it with reset in the middle of CMD.
        bus0.m0_req = 1; bus0.m0_we = 1; bus0.m0_addr = 7'd9; bus0.m0_wdata = 32'hdeadbeef;
        tick();
        checks++; if (bus0.mem_cen !== 1'b0) $display("FAIL rst_pre_cen: got %b exp 0", bus0.mem_cen); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus0.mem_cen !== 1'b1) $display("FAIL rst_cen: got %b exp 1", bus0.mem_cen); else passes++;
        checks++; if (bus0.mem_wen !== 1'b1) $display("FAIL rst_wen: got %b exp 1", bus0.mem_wen); else passes++;
        checks++; if (bus0.mem_oen !== 1'b1) $display("FAIL rst_oen: got %b exp 1", bus0.mem_oen); else passes++;
        checks++; if (bus0.mem_a !== 7'd0) $display("FAIL rst_a: got %0h exp 0", bus0.mem_a); else passes++;
        checks++; if (bus0.mem_d !== 32'd0) $display("FAIL rst_d: got %0h exp 0", bus0.mem_d); else passes++;
        checks++; if ({bus0.m0_ack, bus0.m1_ack} !== 2'b00) $display("FAIL rst_ack: got %b exp 00", {bus0.m0_ack, bus0.m1_ack}); else passes++;
        checks++; if (bus0.m0_rdata !== 32'd0 || bus0.m1_rdata !== 32'd0)
            $display("FAIL rst_rdata: got %0h/%0h exp 0/0", bus0.m0_rdata, bus0.m1_rdata); else passes++;
        bus0.m0_req = 0; bus0.m0_we = 0; bus0.m0_addr = '0; bus0.m0_wdata = '0;
        tick();
        rst = 1'b0;
        cen_low = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus0.mem_cen !== 1'b1 || bus0.m0_ack !== 1'b0) cen_low++;
        end
        checks++; if (cen_low != 0) $display("FAIL rst_idle: got %0d active cycles exp 0", cen_low); else passes++;
    endtask

    task automatic test_write();
        bus0.m0_req = 1; bus0.m0_we = 1; bus0.m0_addr = 7'd4; bus0.m0_wdata = 32'd30;
        tick();
        checks++; if (bus0.mem_cen !== 1'b0) $display("FAIL wr_cen: got %b exp 0", bus0.mem_cen); else passes++;
        checks++; if (bus0.mem_wen !== 1'b0) $display("FAIL wr_wen: got %b exp 0", bus0.mem_wen); else passes++;
        checks++; if (bus0.mem_oen !== 1'b1) $display("FAIL wr_oen: got %b exp 1", bus0.mem_oen); else passes++;
        checks++; if (bus0.mem_a !== 7'd4) $display("FAIL wr_a: got %0d exp 4", bus0.mem_a); else passes++;
        checks++; if (bus0.mem_d !== 32'd30) $display("FAIL wr_d: got %0d exp 30", bus0.mem_d); else passes++;
        checks++; if (bus0.m0_ack !== 1'b0) $display("FAIL wr_early_ack: got %b exp 0", bus0.m0_ack); else passes++;
        tick();
        checks++; if (bus0.m0_ack !== 1'b1 || bus0.m1_ack !== 1'b0)
            $display("FAIL wr_ack: got %b%b exp 10", bus0.m0_ack, bus0.m1_ack); else passes++;
        checks++; if (bus0.mem_cen !== 1'b1 || bus0.mem_wen !== 1'b1)
            $display("FAIL wr_done_ctl: got cen %b wen %b exp 1 1", bus0.mem_cen, bus0.mem_wen); else passes++;
        ref_mem[4] = 32'd30;
        bus0.m0_req = 0;
        tick();
        checks++; if (bus0.m0_ack !== 1'b0) $display("FAIL wr_ack_pulse: got %b exp 0", bus0.m0_ack); else passes++;
    endtask

    task automatic test_read_m1();
        bus0.m1_req = 1; bus0.m1_we = 0; bus0.m1_addr = 7'd4;
        tick();
        checks++; if (bus0.mem_cen !== 1'b0 || bus0.mem_wen !== 1'b1 || bus0.mem_oen !== 1'b0 || bus0.mem_a !== 7'd4)
            $display("FAIL rd_cmd: got cen %b wen %b oen %b a %0d exp 0 1 0 4",
                     bus0.mem_cen, bus0.mem_wen, bus0.mem_oen, bus0.mem_a); else passes++;
        tick();
        checks++; if (bus0.m1_ack !== 1'b1 || bus0.m0_ack !== 1'b0)
            $display("FAIL rd_ack: got m0 %b m1 %b exp 0 1", bus0.m0_ack, bus0.m1_ack); else passes++;
        checks++; if (bus0.m1_rdata !== ref_mem[4]) $display("FAIL rd_m1_rdata: got %0d exp %0d", bus0.m1_rdata, ref_mem[4]); else passes++;
        checks++; if (bus0.m0_rdata !== 32'd0) $display("FAIL rd_m0_rdata: got %0d exp 0", bus0.m0_rdata); else passes++;
        bus0.m1_req = 0;
        tick();
    endtask

    task automatic test_contention();
        int who [$];
        int when [$];
        logic [31:0] dat [$];
        int exp_who [3];
        logic [31:0] exp_dat [3];
        exp_who = '{0, 1, 0};
        exp_dat = '{32'd15, 32'd20, 32'd15};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus0.m0_req = 1; bus0.m0_we = 0; bus0.m0_addr = 7'd0;
        bus0.m1_req = 1; bus0.m1_we = 0; bus0.m1_addr = 7'd1;
        for (int c = 1; c <= 20 && who.size() < 3; c++) begin
            tick();
            if (bus0.m0_ack && bus0.m1_ack) begin
                checks++; $display("FAIL cont_double_ack: got 11 exp one-hot at cycle %0d", c);
            end
            if (bus0.m0_ack) begin who.push_back(0); when.push_back(c); dat.push_back(bus0.m0_rdata); end
            else if (bus0.m1_ack) begin who.push_back(1); when.push_back(c); dat.push_back(bus0.m1_rdata); end
        end
        bus0.m0_req = 0; bus0.m1_req = 0;
        checks++;
        if (who.size() != 3) begin
            $display("FAIL cont_count: got %0d acks exp 3", who.size());
        end else begin
            passes++;
            for (int i = 0; i < 3; i++) begin
                checks++; if (who[i] != exp_who[i]) $display("FAIL cont_owner%0d: got m%0d exp m%0d", i, who[i], exp_who[i]); else passes++;
                checks++; if (dat[i] !== exp_dat[i]) $display("FAIL cont_rdata%0d: got %0d exp %0d", i, dat[i], exp_dat[i]); else passes++;
                checks++; if (when[i] != 2 + 3 * i) $display("FAIL cont_time%0d: got %0d exp %0d", i, when[i], 2 + 3 * i); else passes++;
            end
        end
        tick(); tick();
    endtask

    task automatic test_rd_wait2();
        bus2.m0_req = 1; bus2.m0_we = 0; bus2.m0_addr = 7'd1;
        tick();
        checks++; if (bus2.mem_cen !== 1'b0 || bus2.mem_oen !== 1'b0 || bus2.mem_wen !== 1'b1 || bus2.mem_a !== 7'd1)
            $display("FAIL rw2_cmd: got cen %b oen %b wen %b a %0d exp 0 0 1 1",
                     bus2.mem_cen, bus2.mem_oen, bus2.mem_wen, bus2.mem_a); else passes++;
        for (int w = 0; w < 2; w++) begin
            tick();
            checks++; if (bus2.mem_cen !== 1'b1 || bus2.mem_oen !== 1'b0 || bus2.m0_ack !== 1'b0 || bus2.mem_a !== 7'd1)
                $display("FAIL rw2_wait%0d: got cen %b oen %b ack %b a %0d exp 1 0 0 1",
                         w, bus2.mem_cen, bus2.mem_oen, bus2.m0_ack, bus2.mem_a); else passes++;
        end
        tick();
        checks++; if (bus2.m0_ack !== 1'b1) $display("FAIL rw2_ack: got %b exp 1", bus2.m0_ack); else passes++;
        checks++; if (bus2.m0_rdata !== 32'd20) $display("FAIL rw2_rdata: got %0d exp 20", bus2.m0_rdata); else passes++;
        checks++; if (bus2.mem_oen !== 1'b1 || bus2.mem_cen !== 1'b1)
            $display("FAIL rw2_done_ctl: got oen %b cen %b exp 1 1", bus2.mem_oen, bus2.mem_cen); else passes++;
        bus2.m0_req = 0;
        tick();
    endtask

    task automatic test_reset_in_wait();
        int acks;
        int at;
        bus3.m1_req = 1; bus3.m1_we = 0; bus3.m1_addr = 7'd0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus3.m1_ack !== 1'b0 || bus3.mem_oen !== 1'b1)
            $display("FAIL rw3_rst: got ack %b oen %b exp 0 1", bus3.m1_ack, bus3.mem_oen); else passes++;
        bus3.m1_req = 0;
        tick(); tick();
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus3.m1_ack !== 1'b0) acks++;
        end
        checks++; if (acks != 0) $display("FAIL rw3_no_ack: got %0d acks exp 0", acks); else passes++;
        bus3.m1_req = 1;
        at = -1;
        for (int c = 1; c <= 20 && at < 0; c++) begin
            tick();
            if (bus3.m1_ack === 1'b1) at = c;
        end
        checks++; if (at != 5) $display("FAIL rw3_retry_time: got %0d exp 5", at); else passes++;
        checks++; if (bus3.m1_rdata !== 32'd15) $display("FAIL rw3_retry_rdata: got %0d exp 15", bus3.m1_rdata); else passes++;
        bus3.m1_req = 0;
        tick();
    endtask

    // Two randomly behaving masters on the RD_WAIT=0 instance; transactions are
    // applied to ref_mem in completion order, which is the order they hit the SRAM.
    task automatic test_random();
        logic        pend [2];
        logic        pwe [2];
        logic [6:0]  paddr [2];
        logic [31:0] pwd [2];
        logic [31:0] exp_rd [2];
        int          age [2];
        logic        ack [2];
        logic [31:0] got_rd [2];
        int          last_ack;
        int          must_next;
        int          c;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin pend[k] = 0; pwe[k] = 0; paddr[k] = '0; pwd[k] = '0; exp_rd[k] = '0; age[k] = 0; end
        last_ack = -100;
        must_next = -1;
        c = 0;
        while (c < 400 || ((pend[0] || pend[1]) && c < 430)) begin
            tick();
            c++;
            ack[0] = bus0.m0_ack; ack[1] = bus0.m1_ack;
            got_rd[0] = bus0.m0_rdata; got_rd[1] = bus0.m1_rdata;
            checks++; if (ack[0] && ack[1]) $display("FAIL rnd_double_ack: cycle %0d got 11 exp one-hot", c); else passes++;
            for (int k = 0; k < 2; k++) begin
                if (ack[k] === 1'b1) begin
                    checks++;
                    if (!pend[k]) begin
                        $display("FAIL rnd_spurious_ack: m%0d cycle %0d got ack exp none", k, c);
                    end else begin
                        passes++;
                        if (pwe[k]) ref_mem[paddr[k]] = pwd[k];
                        else        exp_rd[k] = ref_mem[paddr[k]];
                        checks++; if (got_rd[k] !== exp_rd[k])
                            $display("FAIL rnd_rdata: m%0d addr %0d got %0h exp %0h", k, paddr[k], got_rd[k], exp_rd[k]); else passes++;
                        checks++; if (got_rd[1-k] !== exp_rd[1-k])
                            $display("FAIL rnd_other_rdata: m%0d got %0h exp %0h", 1-k, got_rd[1-k], exp_rd[1-k]); else passes++;
                        checks++; if (c - last_ack < 3)
                            $display("FAIL rnd_spacing: got %0d cycles exp >=3", c - last_ack); else passes++;
                        if (must_next >= 0) begin
                            checks++; if (must_next != k) $display("FAIL rnd_rr: got m%0d exp m%0d", k, must_next); else passes++;
                        end
                        must_next = pend[1-k] ? (1 - k) : -1;
                        last_ack = c;
                        pend[k] = 0;
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (pend[k]) begin
                    age[k]++;
                    if (age[k] > 12) begin
                        checks++;
                        $display("FAIL rnd_timeout: m%0d got no ack after %0d cycles exp <=12", k, age[k]);
                        pend[k] = 0;
                        if (must_next == k) must_next = -1;
                    end
                end else if (c < 400 && $urandom_range(0, 2) != 0) begin
                    pend[k] = 1; age[k] = 0;
                    pwe[k] = 1'($urandom_range(0, 1));
                    paddr[k] = 7'($urandom_range(0, 15));
                    pwd[k] = $urandom;
                end
            end
            bus0.m0_req = pend[0]; bus0.m0_we = pwe[0]; bus0.m0_addr = paddr[0]; bus0.m0_wdata = pwd[0];
            bus0.m1_req = pend[1]; bus0.m1_we = pwe[1]; bus0.m1_addr = paddr[1]; bus0.m1_wdata = pwd[1];
        end
        bus0.m0_req = 0; bus0.m1_req = 0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        init_env();
        test_reset();
        test_write();
        test_read_m1();
        test_contention();
        test_rd_wait2();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and access sequencer for the 128x32 data SRAM (HSs18n_128x32 class, active-low CEN/WEN/OEN, clocked on inverted clk).
- Master 0 is the single-cycle MIPS core's load/store port; master 1 is a loader/debug port that fills or inspects data memory.
- Provides req/ack handshakes, round-robin arbitration, programmable read wait states, and fully registered SRAM control.

Parameters:
AW, 7, SRAM address width (word address)
DW, 32, data width
RD_WAIT, 0, extra wait cycles between SRAM read command and data capture; legal range 0..3

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 request; held stable until m0_ack
m0_we  input  1  master 0: 1 = write, 0 = read
m0_addr  input  AW  master 0 word address
m0_wdata  input  DW  master 0 write data
m0_ack  output  1  master 0 one-cycle completion pulse
m0_rdata  output  DW  master 0 read data; valid while m0_ack=1, held until next m0 read completes
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_* for master 1
mem_cen  output  1  SRAM chip enable, active-low
mem_wen  output  1  SRAM write enable, active-low
mem_oen  output  1  SRAM output enable, active-low
mem_a  output  AW  SRAM address
mem_d  output  DW  SRAM write data
mem_q  input  DW  SRAM read data

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state=IDLE; rr_last=1, so master 0 wins the first tie.
  - m0_ack=m1_ack=0; m0_rdata=m1_rdata=0.
  - mem_cen=1, mem_wen=1, mem_oen=1, mem_a=0, mem_d=0.
  - An aborted transaction never acks; its master must re-request.
- All outputs are registered.
- FSM states: IDLE, CMD, WAIT, DONE.
- IDLE: sample m0_req/m1_req.
  - Neither asserted: stay in IDLE.
  - Only one asserted: grant it.
  - Both asserted: grant the master != rr_last.
  - On grant: latch owner, we, addr, wdata; rr_last<=owner; go to CMD.
- CMD (exactly 1 cycle):
  - mem_cen=0, mem_a=addr.
  - Write: mem_wen=0, mem_d=wdata, mem_oen=1; next state DONE.
  - Read: mem_wen=1, mem_oen=0; next state DONE if RD_WAIT=0, else WAIT.
- WAIT (reads only): lasts exactly RD_WAIT cycles via a 2-bit counter.
  - mem_cen=1, mem_oen=0; mem_a held.
  - Then go to DONE.
- Entering DONE on a read: owner's rdata<=mem_q, captured at that edge. The other master's rdata is unchanged.
- DONE (1 cycle):
  - owner's ack=1; other master's ack=0.
  - mem_cen=1, mem_wen=1, mem_oen=1; mem_a and mem_d hold their last value.
  - Next state IDLE.
- Latency, counting edge E as the IDLE edge that grants:
  - write: ack high during cycle E+2;
  - read: ack high during cycle E+2+RD_WAIT.
- Throughput: one transaction per 3+RD_WAIT cycles (writes: 3). IDLE always separates transactions.
- Handshake:
  - The master holds req, we, addr, wdata constant from assertion until it sees ack.
  - It deasserts req in the cycle following ack unless it has a new request ready.
  - A req still high in the following IDLE is treated as a new request.
- A request arriving while the other master is being served waits; it is granted in the next IDLE.
- Under continuous contention, grants strictly alternate.
- At most one ack is high in any cycle; mem_wen=0 only while in CMD with we=1.
- Addresses are used as-is (AW bits); there is no range checking.

Test Plan:
- Reset: assert rst mid-cycle → all outputs at reset values immediately (async); after release with no req, mem_cen stays 1 for 10 cycles.
- m0 write addr 4, data 30 (RD_WAIT=0): req sampled at edge E; mem_cen=0, mem_wen=0, mem_a=4, mem_d=30 during cycle E+1; m0_ack pulse in cycle E+2; mem[4]=30.
- m1 read addr 4 after that write → m1_ack in cycle E+2 with m1_rdata=30; m0_rdata unchanged (0).
- Both masters request reads from addr 0 (=15) and addr 1 (=20) simultaneously after reset, holding req:
  - m0 is served first (rdata 15), then m1 (rdata 20), then m0 again;
  - acks alternate, 3 cycles apart.
- RD_WAIT=2: m0 read addr 1 → mem_cen low for 1 cycle; ack in cycle E+4 with m0_rdata=20; mem_oen low from CMD through WAIT.
- Reset asserted in WAIT of an m1 read (RD_WAIT=3) → no m1_ack ever for that read; after release, a re-issued m1 request completes normally.
